branch_target_buffer: RTL
=========================

# branch_target_buffer

Direct-mapped branch target buffer with 2-bit saturating direction predictors. It sits upstream of the fetch stage. Each cycle it looks up the current fetch PC and drives `btb_target_pc`, `btb_pc_valid` and `btb_pc_predictTaken` into fetch. The execute stage writes resolved branch and jump outcomes back into it through a single update port.

## Interface
- `ENTRIES`, default 16: number of entries. Must be a power of two, minimum 2.
- `IDX_W`, default $clog2(ENTRIES): index width. Derived; do not override.
- `clk` input 1: the single clock; all state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `pc` input 32: current fetch PC, used for lookup.
- `update_en` input 1: resolved control-flow instruction this cycle.
- `update_pc` input 32: PC of the resolved instruction.
- `update_target` input 32: resolved target address.
- `update_taken` input 1: resolved direction.
- `update_is_jump` input 1: unconditional jump (JAL/JALR).
- `btb_target_pc` output 32: predicted target; 0 on miss.
- `btb_pc_valid` output 1: lookup hit.
- `btb_pc_predictTaken` output 1: hit and counter MSB = 1.

## Operation
- **Address split.** Index = `pc[IDX_W+1:2]`. Tag = `pc[31:IDX_W+2]`. `pc[1:0]` is ignored. The update port splits `update_pc` the same way.
- **Entry contents.** `valid`, `tag`, `target[31:0]`, `ctr[1:0]`.
- **Counter states.**
  - 00 = strongly not-taken (SNT)
  - 01 = weakly not-taken (WNT)
  - 10 = weakly taken (WT)
  - 11 = strongly taken (ST)
- **Lookup** is purely combinational from `pc` and the stored entries.
  - Hit = `valid && tag == pc tag`.
  - On hit: `btb_pc_valid`=1, `btb_target_pc`=target, `btb_pc_predictTaken`=`ctr[1]`.
  - On miss: all three outputs are 0.
- **Update**, applied at the clock edge when `update_en`=1 and `rst`=0:
  - **Hit, `update_is_jump`=1:** ctr←ST, target←`update_target`.
  - **Hit, conditional, taken:** ctr←min(ctr+1, 3), target←`update_target`.
  - **Hit, conditional, not taken:** ctr←max(ctr−1, 0). Target unchanged.
  - **Miss (invalid or tag mismatch), taken or jump:** allocate. valid←1, tag←`update_pc` tag, target←`update_target`, ctr←ST for a jump, WT otherwise. Overwrites any aliasing entry.
  - **Miss, not taken:** no change. Not-taken branches are never allocated.
- Counter arithmetic saturates at both ends; it never wraps.
- Exactly one entry is written per update; all other entries hold.

## Timing
- **Reset.** On a rising edge with `rst`=1, all `valid` bits clear and all `ctr` reset to WNT. Tag and target need not reset. From the cycle after that edge, all outputs are 0 for any `pc`. `update_en` is ignored in the reset cycle.
- **Lookup latency.** 0 cycles; outputs follow `pc` within the same cycle.
- **Update latency.** A write at edge N is visible to lookups from the cycle after edge N.
- **Simultaneous lookup and update of the same index.** The lookup returns pre-update contents. There is no write-through bypass.
- **Update during reset.** Reset wins. The update is lost.
- **Stalls.** No stall or flush input. Lookup is stateless; fetch decides whether to use the outputs.

## Test plan
- **Reset clears the table.** Preload entries via updates, assert `rst` for 1 cycle, then sweep `pc` over 0x00–0x3C. Required: `btb_pc_valid`=0, `btb_target_pc`=0 and `btb_pc_predictTaken`=0 for every address.
- **Allocate on taken.** Update pc=0x00000010, target=0x00000100, taken=1, jump=0. Next cycle, pc=0x10 gives valid=1, target=0x100, predictTaken=1 (WT). A not-taken update at pc=0x14 on an empty entry leaves pc=0x14 as a miss.
- **Saturation.** On entry 0x10 (WT): not-taken gives WNT (predictTaken=0), then a second not-taken gives SNT, then a third not-taken stays SNT. Four taken updates then step SNT→WNT→WT→ST and stay at ST. predictTaken=1 once the counter reaches WT.
- **Alias replacement.** With ENTRIES=16, after the 0x10 allocation, update pc=0x50 (same index, different tag), target=0x200, taken=1. Required: pc=0x50 hits with target 0x200, and pc=0x10 misses. Then a not-taken update at 0x90 leaves the 0x50 entry intact.
- **Same-cycle read/write.** Hold pc=0x20 while updating pc=0x20, target=0x300, jump=1 on an empty entry. Required: valid=0 in that cycle; the next cycle gives valid=1, target=0x300, predictTaken=1, counter ST.
- **Update during reset.** Assert `rst` and `update_en` (pc=0x30, taken=1) in the same cycle. Required: pc=0x30 misses afterwards.

Source files
------------

// File: rtl/branch_target_buffer.sv
// rtl/branch_target_buffer.sv - direct-mapped branch target buffer with 2-bit saturating direction counters
module branch_target_buffer #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        update_en,
    input  logic [31:0] update_pc,
    input  logic [31:0] update_target,
    input  logic        update_taken,
    input  logic        update_is_jump,
    output logic [31:0] btb_target_pc,
    output logic        btb_pc_valid,
    output logic        btb_pc_predictTaken
);

    localparam int TAG_W = 32 - IDX_W - 2;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];

    logic [IDX_W-1:0] rd_idx;
    logic [TAG_W-1:0] rd_tag;
    logic             rd_hit;

    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;

    logic             wr_en_d;
    logic [31:0]      wr_target_d;
    logic [1:0]       wr_ctr_d;

    // Byte offset within the instruction word never participates in index or tag.
    logic unused_bits;
    assign unused_bits = ^{pc[1:0], update_pc[1:0]};

    assign rd_idx = pc[IDX_W+1:2];
    assign rd_tag = pc[31:IDX_W+2];
    assign rd_hit = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);

    always_comb begin
        btb_pc_valid        = 1'b0;
        btb_target_pc       = 32'h0;
        btb_pc_predictTaken = 1'b0;
        if (rd_hit) begin
            btb_pc_valid        = 1'b1;
            btb_target_pc       = target_q[rd_idx];
            btb_pc_predictTaken = ctr_q[rd_idx][1];
        end
    end

    assign up_idx = update_pc[IDX_W+1:2];
    assign up_tag = update_pc[31:IDX_W+2];
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    always_comb begin
        wr_en_d     = 1'b0;
        wr_target_d = target_q[up_idx];
        wr_ctr_d    = ctr_q[up_idx];
        if (update_en) begin
            if (up_hit) begin
                wr_en_d = 1'b1;
                if (update_is_jump) begin
                    wr_ctr_d    = CTR_ST;
                    wr_target_d = update_target;
                end else if (update_taken) begin
                    wr_ctr_d    = (ctr_q[up_idx] == CTR_ST) ? CTR_ST : ctr_q[up_idx] + 2'b01;
                    wr_target_d = update_target;
                end else begin
                    wr_ctr_d    = (ctr_q[up_idx] == CTR_SNT) ? CTR_SNT : ctr_q[up_idx] - 2'b01;
                end
            end else if (update_taken || update_is_jump) begin
                // Allocation replaces whatever aliased into this slot.
                wr_en_d     = 1'b1;
                wr_target_d = update_target;
                wr_ctr_d    = update_is_jump ? CTR_ST : CTR_WT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= CTR_WNT;
            end
        end else if (wr_en_d) begin
            valid_q[up_idx]  <= 1'b1;
            tag_q[up_idx]    <= up_tag;
            target_q[up_idx] <= wr_target_d;
            ctr_q[up_idx]    <= wr_ctr_d;
        end
    end

endmodule
